imem_loader: RTL and testbench

//   Writer side of the multicycle core's instruction memory: receives a byte-serial program

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 119 +++++++++++
 tb/tb_imem_loader.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  // Loader side: consumes the byte stream, drives the memory write port.
  modport slave (
    input  in_valid, in_data,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  // Host side: drives the byte stream, observes the memory write port.
  modport master (
    output in_valid, in_data,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory loader: unpacks a framed byte stream (HDR, LEN, 4*N data
// bytes MSB first, XOR checksum) into 32-bit words written from address 0,
// and keeps the core held in reset until a frame completes with a good checksum.
module imem_loader #(
  parameter int          ADDR_W = 5,
  parameter int          DEPTH  = 32,
  parameter logic [7:0]  HDR    = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  imem_loader_if.slave      bus,
  output logic              core_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     word_q, word_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [7:0]      acc_q, acc_d;
  logic [ADDR_W:0] len_q, len_d;
  logic [ADDR_W:0] wc_q, wc_d;
  logic            in_ready;
  logic            xfer;

  // Accepting states take a byte whenever one is offered; WRITE is the bubble.
  assign in_ready = (state_q == S_HDR) || (state_q == S_LEN) ||
                    (state_q == S_DATA) || (state_q == S_CHK);
  assign xfer     = bus.in_valid & in_ready;

  assign bus.in_ready  = in_ready;
  assign bus.mem_we    = (state_q == S_WRITE);
  assign bus.mem_addr  = wc_q[ADDR_W-1:0];
  assign bus.mem_wdata = word_q;

  assign busy       = in_ready || (state_q == S_WRITE);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERR);
  assign core_hold  = (state_q != S_DONE);
  assign word_count = wc_q;

  // State and datapath registers; reset discards any partial word.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      bcnt_q  <= '0;
      acc_q   <= '0;
      len_q   <= '0;
      wc_q    <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      bcnt_q  <= bcnt_d;
      acc_q   <= acc_d;
      len_q   <= len_d;
      wc_q    <= wc_d;
    end
  end

  // Frame parser: next state and datapath updates.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    bcnt_d  = bcnt_q;
    acc_d   = acc_q;
    len_d   = len_q;
    wc_d    = wc_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d = S_HDR;
          word_d  = '0;
          bcnt_d  = '0;
          acc_d   = '0;
          wc_d    = '0;
        end
      end
      S_HDR: begin
        if (xfer) state_d = (bus.in_data == HDR) ? S_LEN : S_ERR;
      end
      S_LEN: begin
        if (xfer) begin
          // Lengths beyond DEPTH would walk past the last address, so reject them.
          if (bus.in_data == 8'd0 || 32'(bus.in_data) > DEPTH) begin
            state_d = S_ERR;
          end else begin
            len_d   = bus.in_data[ADDR_W:0];
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (xfer) begin
          word_d = {word_q[23:0], bus.in_data};
          acc_d  = acc_q ^ bus.in_data;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        wc_d    = wc_q + 1'b1;
        state_d = (wc_d == len_q) ? S_CHK : S_DATA;
      end
      S_CHK: begin
        if (xfer) state_d = (bus.in_data == acc_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames; expected memory writes are queued
// by the stimulus and checked by an independent write monitor.
module tb_imem_loader;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic            clock = 1'b0;
  logic            reset;
  logic            start;
  logic            core_hold, busy, done, error;
  logic [ADDR_W:0] word_count;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(32), .HDR(8'hA5)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .bus        (bus.slave),
    .core_hold  (core_hold),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clock = ~clock;

  int  n_vec  = 0;
  int  n_fail = 0;
  int  n_wr   = 0;
  wr_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every strobe must match the next queued write and sit in the bubble.
  always @(negedge clock) begin
    if (reset === 1'b1 && bus.mem_we === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        n_vec++; n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
        chk("wr_data", bus.mem_wdata, e.data);
        chk("wr_bubble_in_ready", 32'(bus.in_ready), 32'd0);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transfers.
  task automatic send(input logic [7:0] b, input int gap = 0);
    int t;
    bus.in_valid = 1'b0;
    repeat (gap) @(negedge clock);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 200) begin
      @(negedge clock);
      t++;
    end
    if (bus.in_ready !== 1'b1) begin
      n_vec++; n_fail++;
      $display("FAIL send_timeout: got in_ready %b expected 1 for byte %h", bus.in_ready, b);
    end
    @(negedge clock);
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic push_wr(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = ADDR_W'(a);
    e.data = d;
    exp_q.push_back(e);
  endtask

  // The reference two-word frame, hand-computed checksum 0xE2.
  task automatic good2(input string tag);
    int base;
    base = n_wr;
    pulse_start();
    send(8'hA5);
    chk({tag, "_busy_hold"}, {30'd0, busy, core_hold}, 32'd3);
    send(8'h02);
    push_wr(0, 32'h04000800);
    push_wr(1, 32'h08E00006);
    send(8'h04); send(8'h00); send(8'h08); send(8'h00);
    send(8'h08); send(8'hE0); send(8'h00); send(8'h06);
    send(8'hE2);
    chk({tag, "_done"},      32'(done), 32'd1);
    chk({tag, "_error"},     32'(error), 32'd0);
    chk({tag, "_core_hold"}, 32'(core_hold), 32'd0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_wcount"},    32'(word_count), 32'd2);
    chk({tag, "_nwrites"},   32'(n_wr - base), 32'd2);
  endtask

  task automatic reset_vals(input string tag);
    chk({tag, "_in_ready"},  32'(bus.in_ready), 32'd0);
    chk({tag, "_mem_we"},    32'(bus.mem_we), 32'd0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
    chk({tag, "_status"},    {28'd0, busy, done, error, core_hold}, 32'd1);
    chk({tag, "_wcount"},    32'(word_count), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    logic [31:0] w;
    logic [7:0]  acc;

    reset = 1'b0; start = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(negedge clock);
    reset_vals("rst");
    reset = 1'b1;
    @(negedge clock);

    // Basic two-word load.
    good2("load2");

    // Bad header aborts with no writes; re-arm from ERR.
    base = n_wr;
    pulse_start();
    chk("hdr_rearm_done_clr", 32'(done), 32'd0);
    send(8'h5A);
    chk("badhdr_error", 32'(error), 32'd1);
    chk("badhdr_hold",  32'(core_hold), 32'd1);
    chk("badhdr_nwr",   32'(n_wr - base), 32'd0);
    good2("after_err");

    // One-word frame with checksum one bit off (correct is 0x08).
    base = n_wr;
    pulse_start();
    send(8'hA5); send(8'h01);
    push_wr(0, 32'h12345678);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h09);
    chk("badchk_error", 32'(error), 32'd1);
    chk("badchk_hold",  32'(core_hold), 32'd1);
    chk("badchk_done",  32'(done), 32'd0);
    chk("badchk_wcnt",  32'(word_count), 32'd1);
    chk("badchk_nwr",   32'(n_wr - base), 32'd1);

    // Illegal lengths.
    base = n_wr;
    pulse_start();
    send(8'hA5); send(8'h00);
    chk("len0_error", 32'(error), 32'd1);
    pulse_start();
    send(8'hA5); send(8'h21);
    chk("len33_error", 32'(error), 32'd1);
    chk("len33_busy",  32'(busy), 32'd0);
    chk("len_nwr",     32'(n_wr - base), 32'd0);

    // Full-depth frame with random valid gaps.
    base = n_wr;
    acc  = 8'h00;
    pulse_start();
    send(8'hA5, 1); send(8'd32, 2);
    for (int i = 0; i < 32; i++) begin
      w = {8'(i), 8'(i * 3), 8'(~i), 8'(i + 7)};
      push_wr(i, w);
      for (int k = 3; k >= 0; k--) begin
        acc = acc ^ w[k*8 +: 8];
        send(w[k*8 +: 8], int'($urandom_range(0, 3)));
      end
    end
    send(acc, 2);
    chk("full_done",   32'(done), 32'd1);
    chk("full_wcount", 32'(word_count), 32'd32);
    chk("full_nwr",    32'(n_wr - base), 32'd32);
    chk("full_qempty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame after six data bytes, then a clean reload.
    pulse_start();
    send(8'hA5); send(8'h02);
    push_wr(0, 32'h04000800);
    send(8'h04); send(8'h00); send(8'h08); send(8'h00);
    send(8'h08); send(8'hE0);
    reset = 1'b0;
    #1;
    reset_vals("midrst");
    @(negedge clock);
    reset_vals("midrst_edge");
    chk("midrst_qempty", 32'(exp_q.size()), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    good2("post_rst");
    chk("final_qempty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
